// File: rtl/tick_pkg.sv
// Shared constants for tick_sched: default widths, the gravity period table
// indexed by level, and the input auto-repeat period.
package tick_pkg;

    localparam int CNT_W_DEF      = 26;
    localparam int SOFT_SHIFT_DEF = 3;
    localparam int LEVEL_W_DEF    = 3;
    localparam int LEVEL_N        = 2 ** LEVEL_W_DEF;
    localparam int LEVEL_IDX_W    = $clog2(LEVEL_N);

    localparam int unsigned INPUT_PERIOD = 499_999;

    // Entry 0 sits in the least significant 32 bits.
    typedef logic [LEVEL_N-1:0][31:0] level_table_t;

    localparam level_table_t LEVEL_PERIOD = {
        32'd4_999_999, 32'd4_999_999, 32'd4_999_999, 32'd4_999_999,
        32'd9_999_999, 32'd14_999_999, 32'd19_999_999, 32'd24_999_999
    };

endpackage

// File: rtl/tick_counter.sv
// One scheduler channel: counts against a live period, emits a one-cycle tick
// and, when TICK_SCHED_BLINK_EN is defined, a blink flop toggled by each tick.
module tick_counter
    import tick_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             restart,
    input  logic [CNT_W-1:0] period,
    output logic             tick,
    output logic             blink
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (restart) begin
            count_d = '0;
        end else if (!pause) begin
            // ">=" rather than "==" so a shrinking period never wraps through 2^CNT_W.
            if (count_q >= period) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

`ifdef TICK_SCHED_BLINK_EN
    logic blink_q, blink_d;

    always_comb begin
        blink_d = tick_d ? ~blink_q : blink_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: rtl/tick_sched.sv
// Multi-channel tick scheduler: channel 0 runs at the level-driven gravity period,
// the others at externally supplied periods. Blink outputs need TICK_SCHED_BLINK_EN.
module tick_sched
    import tick_pkg::*;
#(
    parameter int           NUM_CH      = 4,
    parameter int           CNT_W       = CNT_W_DEF,
    parameter int           LEVEL_W     = LEVEL_W_DEF,
    parameter int           SOFT_SHIFT  = SOFT_SHIFT_DEF,
    parameter level_table_t LEVEL_TABLE = LEVEL_PERIOD
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic                        pause,
    input  logic [LEVEL_W-1:0]          level,
    input  logic                        soft_drop,
    input  logic [(NUM_CH-1)*CNT_W-1:0] period_i,
    input  logic [NUM_CH-1:0]           restart,
    output logic [NUM_CH-1:0]           tick,
    output logic [NUM_CH-1:0]           blink
);

    logic [LEVEL_IDX_W-1:0]         level_idx;
    logic [CNT_W-1:0]               grav_base;
    logic [CNT_W-1:0]               grav_period;
    logic [NUM_CH-1:0][CNT_W-1:0]   period;

    always_comb begin
        // Levels past the end of the table stay at the fastest entry.
        level_idx = LEVEL_IDX_W'(LEVEL_N - 1);
        if (32'(level) < 32'(LEVEL_N)) begin
            level_idx = LEVEL_IDX_W'(level);
        end

        grav_base   = CNT_W'(LEVEL_TABLE[level_idx]);
        grav_period = grav_base;
        if (soft_drop) begin
            grav_period = grav_base >> SOFT_SHIFT;
            if (grav_period == '0) begin
                grav_period = CNT_W'(1);
            end
        end

        period[0] = grav_period;
        for (int k = 1; k < NUM_CH; k++) begin
            period[k] = period_i[(k-1)*CNT_W +: CNT_W];
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tick_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk    (CLOCK_50),
            .rst    (reset),
            .pause  (pause),
            .restart(restart[k]),
            .period (period[k]),
            .tick   (tick[k]),
            .blink  (blink[k])
        );
    end

endmodule

// File: tb/tb_tick_sched.sv
// Scoreboard bench for tick_sched: stimulus queues expected ticks, a monitor
// pairs each observed tick with the next expectation for that channel.
module tb_tick_sched;
    import tick_pkg::*;

    localparam int NUM_CH     = 2;
    localparam int CNT_W      = 8;
    localparam int LEVEL_W    = 3;
    localparam int SOFT_SHIFT = 3;

    localparam level_table_t TB_TABLE = {
        32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd9
    };

`ifdef TICK_SCHED_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    typedef struct {
        int   ch;
        int   cyc;
        logic blink;
    } exp_t;

    logic                clk       = 1'b0;
    logic                rst       = 1'b1;
    logic                pause     = 1'b0;
    logic                soft_drop = 1'b0;
    logic [LEVEL_W-1:0]  level     = '0;
    logic [CNT_W-1:0]    period_i  = '0;
    logic [NUM_CH-1:0]   restart   = '0;
    logic [NUM_CH-1:0]   watch     = '0;
    logic [NUM_CH-1:0]   tick;
    logic [NUM_CH-1:0]   blink;

    int   cyc;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    tick_sched #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .LEVEL_W    (LEVEL_W),
        .SOFT_SHIFT (SOFT_SHIFT),
        .LEVEL_TABLE(TB_TABLE)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .pause    (pause),
        .level    (level),
        .soft_drop(soft_drop),
        .period_i (period_i),
        .restart  (restart),
        .tick     (tick),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    // Number of active edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (watch[c] && tick[c]) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (idx < 0 && exp_q[i].ch == c) idx = i;
                    end
                    if (idx < 0) begin
                        check($sformatf("tick%0d_unexpected", c), 32'(tick[c]), 32'd0);
                    end else begin
                        check($sformatf("tick%0d_cycle", c), 32'(cyc), 32'(exp_q[idx].cyc));
                        check($sformatf("blink%0d_at_tick", c), 32'(blink[c]), 32'(exp_q[idx].blink));
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    task automatic expect_tick(input int ch, input int c, input bit b);
        exp_t e;
        e.ch    = ch;
        e.cyc   = c;
        e.blink = BLINK_ON & b;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic start_phase(input logic [NUM_CH-1:0] mask);
        @(negedge clk);
        #1;
        watch = '0;
        rst   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        watch = mask;
    endtask

    task automatic drain(input string name);
        #1;
        watch = '0;
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_blink", 32'(blink), 32'd0);

        // Channel 1 with period 3: ticks every 4 cycles.
        period_i = 8'd3;
        start_phase(2'b10);
        expect_tick(1, 4, 1'b1);
        expect_tick(1, 8, 1'b0);
        expect_tick(1, 12, 1'b1);
        wait_cyc(13);
        drain("period3");

        // Gravity period drops from 9 to 4 while count is 7.
        level = 3'd0;
        start_phase(2'b01);
        expect_tick(0, 8, 1'b1);
        expect_tick(0, 13, 1'b0);
        expect_tick(0, 18, 1'b1);
        wait_cyc(7);
        level = 3'd1;
        wait_cyc(19);
        drain("level_change");

        // Soft drop: 9>>3 = 1, then 4>>3 = 0 floored to 1.
        level     = 3'd0;
        soft_drop = 1'b1;
        start_phase(2'b01);
        expect_tick(0, 2, 1'b1);
        expect_tick(0, 4, 1'b0);
        expect_tick(0, 6, 1'b1);
        expect_tick(0, 8, 1'b0);
        expect_tick(0, 10, 1'b1);
        wait_cyc(6);
        level = 3'd1;
        wait_cyc(11);
        drain("soft_drop");
        soft_drop = 1'b0;

        // Pause for 10 edges at count 2 of P=3; gravity channel also frozen at 6.
        level    = 3'd0;
        period_i = 8'd3;
        start_phase(2'b11);
        expect_tick(1, 4, 1'b1);
        expect_tick(1, 18, 1'b0);
        expect_tick(1, 22, 1'b1);
        expect_tick(0, 20, 1'b1);
        wait_cyc(6);
        pause = 1'b1;
        wait_cyc(10);
        check("pause_tick", 32'(tick), 32'd0);
        check("pause_blink1", 32'(blink[1]), 32'(BLINK_ON));
        check("pause_blink0", 32'(blink[0]), 32'd0);
        wait_cyc(16);
        pause = 1'b0;
        wait_cyc(23);
        drain("pause");

        // Restart when count reaches P suppresses the tick; then async reset mid-period.
        period_i = 8'd3;
        start_phase(2'b10);
        expect_tick(1, 8, 1'b1);
        wait_cyc(3);
        restart = 2'b10;
        wait_cyc(4);
        restart = 2'b00;
        wait_cyc(8);
        #1;
        check("pre_reset_tick1", 32'(tick[1]), 32'd1);
        check("pre_reset_blink1", 32'(blink[1]), 32'(BLINK_ON));
        rst = 1'b1;
        #1;
        check("async_reset_tick", 32'(tick), 32'd0);
        check("async_reset_blink", 32'(blink), 32'd0);
        drain("restart");

        // Period 0: tick every cycle.
        period_i = 8'd0;
        start_phase(2'b10);
        for (int i = 1; i <= 6; i++) begin
            expect_tick(1, i, (i % 2) == 1);
        end
        wait_cyc(6);
        drain("period0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
